// File: rtl/wt_dcache_wr_arbiter.sv
// rtl/wt_dcache_wr_arbiter.sv - locked round-robin arbiter for the single D$ write port
module wt_dcache_wr_arbiter #(
    parameter int unsigned NumPorts = 4,
    parameter int unsigned IdxW     = 12,
    parameter int unsigned TagW     = 44,
    parameter int unsigned DataW    = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumPorts-1:0]            req_valid_i,
    input  logic [NumPorts*IdxW-1:0]       req_index_i,
    input  logic [NumPorts*TagW-1:0]       req_tag_i,
    input  logic [NumPorts*DataW-1:0]      req_wdata_i,
    input  logic [NumPorts*(DataW/8)-1:0]  req_be_i,
    input  logic [NumPorts*2-1:0]          req_size_i,
    output logic [NumPorts-1:0]            req_gnt_o,
    output logic                           wr_req_o,
    output logic [IdxW-1:0]                wr_index_o,
    output logic [TagW-1:0]                wr_tag_o,
    output logic [DataW-1:0]               wr_wdata_o,
    output logic [DataW/8-1:0]             wr_be_o,
    output logic [1:0]                     wr_size_o,
    input  logic                           wr_gnt_i,
    output logic                           busy_o,
    output logic                           proto_err_o
);
    localparam int unsigned SelW = $clog2(NumPorts);
    localparam int unsigned BeW  = DataW / 8;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e              state_q, state_d;
    logic [SelW-1:0]     sel_q, sel_d, rr_ptr_q, rr_ptr_d;
    logic                proto_err_q, proto_err_d;
    logic [SelW-1:0]     pick, idx, mux_sel;
    logic                pick_valid;
    logic                req_active, busy;
    logic [NumPorts-1:0] gnt;

    function automatic logic [SelW-1:0] wrap_inc(input logic [SelW-1:0] p);
        if (p == SelW'(NumPorts - 1)) return '0;
        return p + SelW'(1);
    endfunction

    // First pending requester at or after rr_ptr_q, wrapping around
    always_comb begin
        pick       = rr_ptr_q;
        pick_valid = 1'b0;
        idx        = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            idx = SelW'((32'(rr_ptr_q) + i) % NumPorts);
            if (!pick_valid && req_valid_i[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        proto_err_d = proto_err_q;
        req_active  = 1'b0;
        busy        = 1'b0;
        mux_sel     = pick;
        gnt         = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    req_active = 1'b1;
                    if (wr_gnt_i) begin
                        gnt[pick] = 1'b1;
                        rr_ptr_d  = wrap_inc(pick);
                    end else begin
                        sel_d   = pick;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                busy    = 1'b1;
                mux_sel = sel_q;
                // A withdrawn store is dropped without advancing fairness
                if (!req_valid_i[sel_q]) begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    req_active = 1'b1;
                    if (wr_gnt_i) begin
                        gnt[sel_q] = 1'b1;
                        rr_ptr_d   = wrap_inc(sel_q);
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign wr_req_o    = req_active & ~rst_i;
    assign req_gnt_o   = rst_i ? '0 : gnt;
    assign busy_o      = busy & ~rst_i;
    assign proto_err_o = proto_err_q & ~rst_i;

    assign wr_index_o = wr_req_o ? req_index_i[mux_sel*IdxW +: IdxW]  : '0;
    assign wr_tag_o   = wr_req_o ? req_tag_i[mux_sel*TagW +: TagW]    : '0;
    assign wr_wdata_o = wr_req_o ? req_wdata_i[mux_sel*DataW +: DataW] : '0;
    assign wr_be_o    = wr_req_o ? req_be_i[mux_sel*BeW +: BeW]       : '0;
    assign wr_size_o  = wr_req_o ? req_size_i[mux_sel*2 +: 2]         : '0;
endmodule

// File: tb/tb_wt_dcache_wr_arbiter.sv
// tb/tb_wt_dcache_wr_arbiter.sv - bench for wt_dcache_wr_arbiter
module tb_wt_dcache_wr_arbiter;
    localparam int NP = 4;
    localparam int IW = 12;
    localparam int TW = 44;
    localparam int DW = 64;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NP-1:0]    req_valid;
    logic [NP*IW-1:0] req_index;
    logic [NP*TW-1:0] req_tag;
    logic [NP*DW-1:0] req_wdata;
    logic [NP*BW-1:0] req_be;
    logic [NP*2-1:0]  req_size;
    logic [NP-1:0]    req_gnt;
    logic             wr_req, wr_gnt, busy, proto_err;
    logic [IW-1:0]    wr_index;
    logic [TW-1:0]    wr_tag;
    logic [DW-1:0]    wr_wdata;
    logic [BW-1:0]    wr_be;
    logic [1:0]       wr_size;

    logic [IW-1:0] p_index[NP];
    logic [TW-1:0] p_tag[NP];
    logic [DW-1:0] p_wdata[NP];
    logic [BW-1:0] p_be[NP];
    logic [1:0]    p_size[NP];

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            req_index[i*IW +: IW] = p_index[i];
            req_tag[i*TW +: TW]   = p_tag[i];
            req_wdata[i*DW +: DW] = p_wdata[i];
            req_be[i*BW +: BW]    = p_be[i];
            req_size[i*2 +: 2]    = p_size[i];
        end
    end

    wt_dcache_wr_arbiter #(.NumPorts(NP), .IdxW(IW), .TagW(TW), .DataW(DW)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_index_i(req_index),
        .req_tag_i(req_tag), .req_wdata_i(req_wdata), .req_be_i(req_be), .req_size_i(req_size),
        .req_gnt_o(req_gnt), .wr_req_o(wr_req), .wr_index_o(wr_index), .wr_tag_o(wr_tag),
        .wr_wdata_o(wr_wdata), .wr_be_o(wr_be), .wr_size_o(wr_size), .wr_gnt_i(wr_gnt),
        .busy_o(busy), .proto_err_o(proto_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: locked port (-1 when free), next-priority port, sticky error
    int            m_lock = -1;
    int            m_ptr  = 0;
    bit            m_err  = 1'b0;
    int            exp_sel;
    logic [NP-1:0] exp_gnt;
    logic [NP-1:0] last_gnt = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic new_payload(input int i);
        p_index[i] = IW'($urandom);
        p_tag[i]   = TW'({$urandom, $urandom});
        p_wdata[i] = {$urandom, $urandom};
        p_be[i]    = BW'($urandom);
        p_size[i]  = 2'($urandom);
    endtask

    task automatic compare_model();
        int p;
        #2;
        exp_sel = -1;
        if (!rst) begin
            if (m_lock >= 0) begin
                if (req_valid[m_lock]) exp_sel = m_lock;
            end else begin
                for (int i = 0; i < NP; i++) begin
                    p = (m_ptr + i) % NP;
                    if (exp_sel < 0 && req_valid[p]) exp_sel = p;
                end
            end
        end
        exp_gnt = '0;
        if (exp_sel >= 0 && wr_gnt) exp_gnt[exp_sel] = 1'b1;
        chk("wr_req", 64'(wr_req), 64'(exp_sel >= 0));
        chk("req_gnt", 64'(req_gnt), 64'(exp_gnt));
        chk("busy", 64'(busy), 64'(!rst && m_lock >= 0));
        chk("proto_err", 64'(proto_err), 64'(!rst && m_err));
        chk("wr_index", 64'(wr_index), exp_sel >= 0 ? 64'(p_index[exp_sel]) : 64'd0);
        chk("wr_tag", 64'(wr_tag), exp_sel >= 0 ? 64'(p_tag[exp_sel]) : 64'd0);
        chk("wr_wdata", wr_wdata, exp_sel >= 0 ? p_wdata[exp_sel] : 64'd0);
        chk("wr_be", 64'(wr_be), exp_sel >= 0 ? 64'(p_be[exp_sel]) : 64'd0);
        chk("wr_size", 64'(wr_size), exp_sel >= 0 ? 64'(p_size[exp_sel]) : 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_lock = -1; m_ptr = 0; m_err = 1'b0;
        end else if (m_lock >= 0) begin
            if (!req_valid[m_lock]) begin
                m_err = 1'b1; m_lock = -1;
            end else if (wr_gnt) begin
                m_ptr = (m_lock + 1) % NP; m_lock = -1;
            end
        end else if (exp_sel >= 0) begin
            if (wr_gnt) m_ptr = (exp_sel + 1) % NP;
            else        m_lock = exp_sel;
        end
        last_gnt = exp_gnt;
        #1;
    endtask

    task automatic cycle();
        compare_model();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; wr_gnt = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; wr_gnt = 1'b0;
        for (int i = 0; i < NP; i++) new_payload(i);
        do_reset();
        cycle();

        // Single requester, zero-cycle grant, then pointer moves to port 1
        req_valid = 4'b0001; wr_gnt = 1'b1;
        compare_model(); chk("single_gnt", 64'(req_gnt), 64'h1); tick();
        req_valid = 4'b0011;
        compare_model(); chk("ptr_after_p0", 64'(req_gnt), 64'h2); tick();

        // Full contention rotates through every port
        do_reset();
        req_valid = 4'b1111; wr_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            compare_model();
            chk("rr_seq", 64'(req_gnt), 64'(1) << (i % NP));
            chk("rr_idx", 64'(wr_index), 64'(p_index[i % NP]));
            tick();
        end

        // Lock on port 2 while port 1 joins; lock must hold
        do_reset();
        req_valid = 4'b0100; wr_gnt = 1'b0;
        cycle();
        req_valid = 4'b0110;
        for (int i = 0; i < 2; i++) begin
            compare_model();
            chk("lock_busy", 64'(busy), 64'h1);
            chk("lock_idx", 64'(wr_index), 64'(p_index[2]));
            tick();
        end
        wr_gnt = 1'b1;
        compare_model(); chk("lock_gnt", 64'(req_gnt), 64'h4); tick();
        req_valid = 4'b0010;
        compare_model(); chk("after_lock", 64'(req_gnt), 64'h2); tick();

        // Port 3 withdraws while locked
        do_reset();
        req_valid = 4'b1000; wr_gnt = 1'b0;
        cycle();
        req_valid = 4'b0000;
        compare_model(); chk("drop_req", 64'(wr_req), 64'h0); tick();
        req_valid = 4'b0001; wr_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            compare_model(); chk("err_sticky", 64'(proto_err), 64'h1); tick();
        end

        // Reset while locked on port 1
        do_reset();
        req_valid = 4'b0010; wr_gnt = 1'b0;
        cycle();
        rst = 1'b1; wr_gnt = 1'b1;
        cycle();
        compare_model(); chk("rst_lock_req", 64'(wr_req), 64'h0); tick();
        rst = 1'b0; req_valid = 4'b0011;
        compare_model(); chk("rst_ptr0", 64'(req_gnt), 64'h1); tick();

        // Grant with nothing pending is ignored
        req_valid = 4'b0000; wr_gnt = 1'b1;
        compare_model(); chk("idle_gnt", 64'(req_gnt), 64'h0); tick();
        req_valid = 4'b1111;
        compare_model(); chk("idle_ptr", 64'(req_gnt), 64'h2); tick();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (!req_valid[i] || last_gnt[i]) begin
                    req_valid[i] = ($urandom_range(2) == 0);
                    if (req_valid[i]) new_payload(i);
                end else if ($urandom_range(31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            wr_gnt = 1'($urandom);
            rst    = ($urandom_range(79) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
